s27_bist: RTL and testbench
===========================

# s27_bist

Built-in self-test driver for the s27 sequential benchmark core. Acts as the opposite end of the core's interface: it produces the primary-input stimulus G0–G3 and consumes the primary output G17. After an initialization phase, it drives pseudo-random patterns from a 4-bit LFSR and compacts the core's responses into a multiple-input signature register (MISR). The test harness then reads back a pass/fail result and the raw signature.

## Interface
Parameters:
- PATTERNS, 15: number of RUN cycles (patterns applied); must be ≥1.
- INIT_CYC, 3: cycles the fixed init vector is held before RUN; 0 allowed (skips INIT).
- INIT_VEC, 4'b0000: {G3,G2,G1,G0} driven during INIT.
- SEED, 4'b0001: LFSR load value; must be non-zero.
- SIG_W, 8: MISR width.
- TAPS, 8'hB8: MISR feedback mask (bit i set means sig[i] is in the feedback).
- GOLDEN, 8'h00: expected signature; PASS compares against this.

Ports:
- CK, in, 1: clock, rising edge.
- RST, in, 1: asynchronous reset, active-high.
- START, in, 1: begin a test; sampled only in IDLE.
- G17, in, 1: core response.
- G0, G1, G2, G3, out, 1 each: stimulus to the core; all registered.
- BUSY, out, 1: high in INIT and RUN.
- DONE, out, 1: one-cycle pulse at test end.
- SIGNATURE, out, SIG_W: MISR contents.
- PASS, out, 1: SIGNATURE == GOLDEN; updated on entry to DONE.

## Operation
- FSM states: IDLE, INIT, RUN, DONE.
- IDLE
  - G[3:0] = 0; LFSR holds SEED.
  - START=1 at an edge → INIT, or → RUN if INIT_CYC=0.
  - On that edge, SIGNATURE is cleared to 0, PASS is cleared to 0, and the cycle counter is cleared.
- INIT
  - G[3:0] = INIT_VEC; G17 is ignored.
  - Leaves for RUN after exactly INIT_CYC cycles.
- RUN
  - G[3:0] = lfsr[3:0] (G3 = lfsr[3]).
  - At each edge:
    - sig ← {sig[SIG_W-2:0], (^(sig & TAPS)) ^ G17};
    - lfsr ← {lfsr[2:0], lfsr[3]^lfsr[0]} (x^4+x^3+1, period 15).
  - After PATTERNS cycles → DONE.
- Pattern sequence from SEED 0001: 0001, 0011, 0111, 1111, 1110, 1101, 1010, 0101, 1011, 0110, 1100, 1001, 0010, 0100, 1000, then 0001 again. For PATTERNS > 15 the sequence wraps naturally.
- DONE
  - DONE=1 for one cycle; G[3:0] = 0; PASS is valid; then → IDLE with the LFSR reloaded to SEED.
- SIGNATURE and PASS hold their values in IDLE until the next accepted START.
- START is ignored in INIT, RUN and DONE; there is no queueing.
- Counter width: clog2(max(PATTERNS, INIT_CYC) + 1).

## Timing
- Reset values (asynchronous): state = IDLE, G0–G3 = 0, BUSY = 0, DONE = 0, SIGNATURE = 0, PASS = 0, lfsr = SEED, counter = 0.
- Call the edge that samples START edge 0:
  - BUSY rises after edge 0.
  - INIT occupies cycles 1 … INIT_CYC.
  - RUN occupies the next PATTERNS cycles.
  - DONE is high in cycle INIT_CYC + PATTERNS + 1.
  - BUSY falls in the same cycle DONE rises.
- G17 is sampled combinationally in the same cycle as the stimulus that produced it. The core path is combinational from inputs to G17, with no pipeline offset.
- The next START is accepted one cycle after DONE, at the earliest.
- RST asserted mid-test aborts immediately: no DONE pulse, and SIGNATURE and PASS return to 0.
- START held high continuously starts a new test each time the FSM returns to IDLE, one cycle after every DONE.

## Test plan
- Reset: RST=1 mid-RUN → next sample shows all outputs 0 and BUSY=0; no DONE pulse follows.
- Stimulus order, defaults, START pulse:
  - G[3:0] is 0000 for 3 INIT cycles, then 0001, 0011, 0111, 1111, … for 15 cycles.
  - DONE appears exactly 19 cycles after the START edge.
- Constant response:
  - G17 tied 0 → SIGNATURE = 8'h00 and PASS = 1 (GOLDEN = 8'h00).
  - G17 tied 1 → SIGNATURE = 8'h1C and PASS = 0.
- INIT_CYC=0, PATTERNS=4, G17 = 1 → BUSY for 4 cycles, G shows 0001, 0011, 0111, 1111, SIGNATURE = 8'h0F.
- START asserted during RUN and in the DONE cycle is ignored. START held high → back-to-back tests, each restarting from SEED with the signature cleared, producing identical signatures.
- s27 core connected, GOLDEN set to the signature from the reference model → PASS = 1. Injecting a stuck-at-0 on G17 → PASS = 0.

Source files
------------

// File: rtl/s27_bist.sv
// rtl/s27_bist.sv - BIST driver for the s27 core: LFSR stimulus on G0-G3, MISR compaction of G17.
module s27_bist #(
  parameter int               PATTERNS = 15,
  parameter int               INIT_CYC = 3,
  parameter logic [3:0]       INIT_VEC = 4'b0000,
  parameter logic [3:0]       SEED     = 4'b0001,
  parameter int               SIG_W    = 8,
  parameter logic [SIG_W-1:0] TAPS     = SIG_W'(8'hB8),
  parameter logic [SIG_W-1:0] GOLDEN   = '0
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             START,
  input  logic             G17,
  output logic             G0,
  output logic             G1,
  output logic             G2,
  output logic             G3,
  output logic             BUSY,
  output logic             DONE,
  output logic [SIG_W-1:0] SIGNATURE,
  output logic             PASS
);

  typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_RUN, ST_DONE} state_t;

  localparam int MAXC = (PATTERNS > INIT_CYC) ? PATTERNS : INIT_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] INIT_LAST = CW'((INIT_CYC > 0) ? INIT_CYC - 1 : 0);
  localparam logic [CW-1:0] RUN_LAST  = CW'(PATTERNS - 1);

  state_t          state;
  logic [3:0]      lfsr;
  logic [CW-1:0]   cnt;
  logic [3:0]      lfsr_next;
  logic [SIG_W-1:0] sig_next;

  // x^4+x^3+1 stepping and MISR compaction of the current response
  assign lfsr_next = {lfsr[2:0], lfsr[3] ^ lfsr[0]};
  assign sig_next  = {SIGNATURE[SIG_W-2:0], (^(SIGNATURE & TAPS)) ^ G17};

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state            <= ST_IDLE;
      {G3, G2, G1, G0} <= 4'b0000;
      BUSY             <= 1'b0;
      DONE             <= 1'b0;
      SIGNATURE        <= '0;
      PASS             <= 1'b0;
      lfsr             <= SEED;
      cnt              <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START) begin
            SIGNATURE <= '0;
            PASS      <= 1'b0;
            cnt       <= '0;
            BUSY      <= 1'b1;
            if (INIT_CYC == 0) begin
              state            <= ST_RUN;
              {G3, G2, G1, G0} <= lfsr;
            end else begin
              state            <= ST_INIT;
              {G3, G2, G1, G0} <= INIT_VEC;
            end
          end
        end
        ST_INIT: begin
          if (cnt == INIT_LAST) begin
            cnt              <= '0;
            state            <= ST_RUN;
            {G3, G2, G1, G0} <= lfsr;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RUN: begin
          SIGNATURE <= sig_next;
          lfsr      <= lfsr_next;
          // G is registered, so it is loaded with the pattern for the coming cycle
          if (cnt == RUN_LAST) begin
            state            <= ST_DONE;
            {G3, G2, G1, G0} <= 4'b0000;
            BUSY             <= 1'b0;
            DONE             <= 1'b1;
            PASS             <= (sig_next == GOLDEN);
            cnt              <= '0;
          end else begin
            cnt              <= cnt + 1'b1;
            {G3, G2, G1, G0} <= lfsr_next;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          lfsr  <= SEED;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_s27_bist.sv
// tb/tb_s27_bist.sv - directed self-checking bench for s27_bist.
module tb_s27_bist;

  // s27 netlist: st = {G5,G6,G7}; returns {G17, next G5, next G6, next G7}
  function automatic logic [3:0] s27_step(input logic [2:0] st, input logic [3:0] g);
    logic g5, g6, g7, g8, g9, g10, g11, g12, g13, g14, g15, g16;
    {g5, g6, g7} = st;
    g14 = ~g[0];
    g8  = g14 & g6;
    g12 = ~(g[1] | g7);
    g15 = g12 | g8;
    g16 = g[3] | g8;
    g9  = ~(g16 & g15);
    g11 = ~(g5 | g9);
    g10 = ~(g14 | g11);
    g13 = ~(g[2] | g12);
    return {~g11, g10, g11, g13};
  endfunction

  // Reference signature for the core starting from the all-zero state
  function automatic logic [7:0] s27_golden();
    logic [2:0] st;
    logic [3:0] lf;
    logic [7:0] sig;
    logic [3:0] r;
    st  = 3'b000;
    lf  = 4'b0001;
    sig = 8'h00;
    for (int i = 0; i < 15; i++) begin
      r   = s27_step(st, lf);
      sig = {sig[6:0], (^(sig & 8'hB8)) ^ r[3]};
      st  = r[2:0];
      lf  = {lf[2:0], lf[3] ^ lf[0]};
    end
    return sig;
  endfunction

  localparam logic [7:0] S27_GOLDEN = s27_golden();

  logic CK, RST;
  logic start, g17_val;
  logic g0, g1, g2, g3, busy, done, pass;
  logic [7:0] signature;

  logic start4;
  logic d4_g0, d4_g1, d4_g2, d4_g3, d4_busy, d4_done, d4_pass;
  logic [7:0] d4_sig;

  logic start_s, stuck, s_g17;
  logic s_g0, s_g1, s_g2, s_g3, s_busy, s_done, s_pass;
  logic [7:0] s_sig;
  logic [2:0] core_st;
  logic [3:0] core_out;

  int checks = 0;
  int errors = 0;

  logic [3:0] seq [0:14] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5,
                             4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8};

  s27_bist dut (
    .CK(CK), .RST(RST), .START(start), .G17(g17_val),
    .G0(g0), .G1(g1), .G2(g2), .G3(g3),
    .BUSY(busy), .DONE(done), .SIGNATURE(signature), .PASS(pass)
  );

  s27_bist #(.PATTERNS(4), .INIT_CYC(0)) dut4 (
    .CK(CK), .RST(RST), .START(start4), .G17(1'b1),
    .G0(d4_g0), .G1(d4_g1), .G2(d4_g2), .G3(d4_g3),
    .BUSY(d4_busy), .DONE(d4_done), .SIGNATURE(d4_sig), .PASS(d4_pass)
  );

  s27_bist #(.GOLDEN(S27_GOLDEN)) dut_s27 (
    .CK(CK), .RST(RST), .START(start_s), .G17(s_g17),
    .G0(s_g0), .G1(s_g1), .G2(s_g2), .G3(s_g3),
    .BUSY(s_busy), .DONE(s_done), .SIGNATURE(s_sig), .PASS(s_pass)
  );

  assign core_out = s27_step(core_st, {s_g3, s_g2, s_g1, s_g0});
  assign s_g17    = stuck ? 1'b0 : core_out[3];

  always @(posedge CK or posedge RST) begin
    if (RST) core_st <= 3'b000;
    else     core_st <= core_out[2:0];
  end

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks one default-parameter test on dut; call right after START is set
  task automatic run_check(input logic [7:0] exp_sig, input logic exp_pass,
                           input bit hold, input bit poke);
    logic [5:0] exp_v;
    for (int c = 1; c <= 19; c++) begin
      @(negedge CK);
      if (c <= 3)       exp_v = 6'b000010;
      else if (c <= 18) exp_v = {seq[c-4], 2'b10};
      else              exp_v = 6'b000001;
      chk($sformatf("cyc%0d", c), {g3, g2, g1, g0, busy, done}, exp_v);
      if (c == 1) begin
        chk("sig_cleared", signature, 8'h00);
        chk("pass_cleared", pass, 1'b0);
        if (!hold) start = 1'b0;
      end
      if (poke && c == 10) start = 1'b1;
      if (poke && c == 11) start = 1'b0;
      if (poke && c == 19) start = 1'b1;
      if (c == 19) begin
        chk("signature", signature, exp_sig);
        chk("pass", pass, exp_pass);
      end
    end
  endtask

  initial begin
    int done_seen;
    RST = 1'b1; start = 1'b0; g17_val = 1'b0; start4 = 1'b0; start_s = 1'b0; stuck = 1'b0;
    repeat (2) @(negedge CK);
    RST = 1'b0;
    @(negedge CK);
    chk("rst_outs", {g3, g2, g1, g0, busy, done, pass}, 7'b0);
    chk("rst_sig", signature, 8'h00);

    // G17 tied low
    start = 1'b1;
    run_check(8'h00, 1'b1, 1'b0, 1'b0);
    @(negedge CK);
    chk("idle_after_a", {g3, g2, g1, g0, busy, done}, 6'b0);

    // G17 tied high, START poked during RUN and in the DONE cycle
    g17_val = 1'b1;
    start = 1'b1;
    run_check(8'h1C, 1'b0, 1'b0, 1'b1);
    @(negedge CK);
    start = 1'b0;
    chk("ignored_c20", {g3, g2, g1, g0, busy, done}, 6'b0);
    @(negedge CK);
    chk("ignored_c21", {g3, g2, g1, g0, busy, done}, 6'b0);
    chk("sig_held", signature, 8'h1C);
    chk("pass_held", pass, 1'b0);

    // START held high: back-to-back tests
    start = 1'b1;
    run_check(8'h1C, 1'b0, 1'b1, 1'b0);
    @(negedge CK);
    chk("b2b_gap", {g3, g2, g1, g0, busy, done}, 6'b0);
    chk("b2b_gap_sig", signature, 8'h1C);
    run_check(8'h1C, 1'b0, 1'b1, 1'b0);
    @(negedge CK);
    start = 1'b0;
    @(negedge CK);
    chk("b2b_stop", {busy, done}, 2'b00);

    // INIT_CYC=0, PATTERNS=4, G17=1
    start4 = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge CK);
      if (c == 1) start4 = 1'b0;
      if (c <= 4)
        chk($sformatf("d4_cyc%0d", c), {d4_g3, d4_g2, d4_g1, d4_g0, d4_busy, d4_done},
            {seq[c-1], 2'b10});
      else
        chk("d4_done", {d4_g3, d4_g2, d4_g1, d4_g0, d4_busy, d4_done}, 6'b000001);
    end
    chk("d4_sig", d4_sig, 8'h0F);
    chk("d4_pass", d4_pass, 1'b0);

    // Reset mid-RUN aborts with no DONE
    start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge CK);
      if (c == 1) start = 1'b0;
    end
    RST = 1'b1;
    #1;
    chk("abort_outs", {g3, g2, g1, g0, busy, done, pass}, 7'b0);
    chk("abort_sig", signature, 8'h00);
    @(negedge CK);
    RST = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge CK);
      if (done || busy) done_seen++;
    end
    chk("abort_no_done", done_seen, 0);

    // s27 core attached, then G17 stuck-at-0
    start_s = 1'b1;
    for (int c = 1; c <= 19; c++) begin
      @(negedge CK);
      if (c == 1) start_s = 1'b0;
    end
    chk("s27_done", s_done, 1'b1);
    chk("s27_sig", s_sig, S27_GOLDEN);
    chk("s27_pass", s_pass, 1'b1);
    @(negedge CK);
    stuck = 1'b1;
    start_s = 1'b1;
    for (int c = 1; c <= 19; c++) begin
      @(negedge CK);
      if (c == 1) start_s = 1'b0;
    end
    chk("stuck_done", s_done, 1'b1);
    chk("stuck_sig", s_sig, 8'h00);
    chk("stuck_pass", s_pass, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
